// File: rtl/player_life_ctrl_pkg.sv
// rtl/player_life_ctrl_pkg.sv - shared types and widths for the player life controller
package player_life_ctrl_pkg;

  localparam int LIVES_W     = 3;
  localparam int FRAME_CNT_W = 10;

  typedef enum logic [2:0] {
    IDLE_ST,
    PLAY_ST,
    HIT_ST,
    RESPAWN_ST,
    INVULN_ST,
    GAMEOVER_ST
  } state_e;

  function automatic bit is_pow2(int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/player_life_ctrl_if.sv
// rtl/player_life_ctrl_if.sv - game-event inputs and player-status outputs of the life controller
interface player_life_ctrl_if;

  logic                                      startOfFrame;
  logic                                      start_game;
  logic                                      col_player_enemy;
  logic                                      col_player_star;
  logic [player_life_ctrl_pkg::LIVES_W-1:0]  lives;
  logic                                      GameOver;
  logic                                      star;
  logic                                      respawn;
  logic                                      invulnerable;
  logic                                      player_visible;

  modport master (
    output startOfFrame, start_game, col_player_enemy, col_player_star,
    input  lives, GameOver, star, respawn, invulnerable, player_visible
  );

  modport slave (
    input  startOfFrame, start_game, col_player_enemy, col_player_star,
    output lives, GameOver, star, respawn, invulnerable, player_visible
  );

endinterface

// File: rtl/player_life_ctrl_frame_countdown.sv
// rtl/player_life_ctrl_frame_countdown.sv - loadable down-counter stepped once per frame
// Load wins over a coincident frame tick; the count holds at zero.
module player_life_ctrl_frame_countdown
  import player_life_ctrl_pkg::*;
#(
  parameter int W = FRAME_CNT_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         start_of_frame_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (start_of_frame_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/player_life_ctrl.sv
// rtl/player_life_ctrl.sv - sequences play, hit, respawn, invulnerability and game-over
// Optional PLAYER_STAR_TIMEOUT_EN: star power expires after STAR_FRAMES frames (sticky otherwise).
module player_life_ctrl
  import player_life_ctrl_pkg::*;
#(
  parameter int INITIAL_LIVES = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 4,
  parameter int STAR_FRAMES   = 300
) (
  input  logic               clk,
  input  logic               resetN,
  player_life_ctrl_if.slave  bus
);

  if (INITIAL_LIVES < 1 || INITIAL_LIVES > 7) begin : g_chk_lives
    $error("INITIAL_LIVES must be 1..7");
  end
  if (INVULN_FRAMES < 1 || INVULN_FRAMES > 1023) begin : g_chk_invuln
    $error("INVULN_FRAMES must be 1..1023");
  end
  if (BLINK_PERIOD < 2 || !is_pow2(BLINK_PERIOD)) begin : g_chk_blink
    $error("BLINK_PERIOD must be a power of 2, >= 2");
  end
  if (STAR_FRAMES < 1 || STAR_FRAMES > 1023) begin : g_chk_star
    $error("STAR_FRAMES must be 1..1023");
  end

  localparam int                     BLINK_W     = $clog2(BLINK_PERIOD);
  localparam logic [LIVES_W-1:0]     LIVES_INIT  = LIVES_W'(INITIAL_LIVES);
  localparam logic [FRAME_CNT_W-1:0] INVULN_LOAD = FRAME_CNT_W'(INVULN_FRAMES);
  localparam logic [BLINK_W-1:0]     BLINK_LAST  = BLINK_W'(BLINK_PERIOD - 1);

  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 star_q, star_d;
  logic                 visible_q, visible_d;
  logic                 armed_q, armed_d;

  logic                   frame_inv;
  logic                   inv_zero;
  logic [FRAME_CNT_W-1:0] inv_count;
  logic                   restart;
  logic                   pickup_ok;

  // Frame ticks only count in the state that owns the counter, so a tick on a transition edge is not carried over.
  assign frame_inv = bus.startOfFrame && (state_q == INVULN_ST);

  player_life_ctrl_frame_countdown #(.W(FRAME_CNT_W)) u_invuln_cnt (
    .clk              (clk),
    .resetN           (resetN),
    .load_i           (state_q == RESPAWN_ST),
    .load_val_i       (INVULN_LOAD),
    .start_of_frame_i (frame_inv),
    .count_o          (inv_count),
    .zero_o           (inv_zero)
  );

  assign restart = bus.start_game &&
                   ((state_q == IDLE_ST) || ((state_q == GAMEOVER_ST) && armed_q));

  // An enemy hit in PLAY_ST without star power takes precedence over a same-cycle pickup.
  assign pickup_ok = bus.col_player_star &&
                     (((state_q == PLAY_ST) && !(bus.col_player_enemy && !star_q)) ||
                      (state_q == INVULN_ST));

`ifdef PLAYER_STAR_TIMEOUT_EN
  localparam logic [FRAME_CNT_W-1:0] STAR_LOAD = FRAME_CNT_W'(STAR_FRAMES);

  logic                   star_zero;
  logic [FRAME_CNT_W-1:0] star_count;

  player_life_ctrl_frame_countdown #(.W(FRAME_CNT_W)) u_star_cnt (
    .clk              (clk),
    .resetN           (resetN),
    .load_i           (pickup_ok),
    .load_val_i       (STAR_LOAD),
    .start_of_frame_i (bus.startOfFrame && star_q),
    .count_o          (star_count),
    .zero_o           (star_zero)
  );

  a_star_range: assert property (@(posedge clk) disable iff (!resetN) star_count <= STAR_LOAD);
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE_ST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_ST:     if (restart) state_d = RESPAWN_ST;
      PLAY_ST:     if (bus.col_player_enemy && !star_q) state_d = HIT_ST;
      HIT_ST:      state_d = (lives_q == LIVES_W'(1)) ? GAMEOVER_ST : RESPAWN_ST;
      RESPAWN_ST:  state_d = INVULN_ST;
      INVULN_ST:   if (inv_zero) state_d = PLAY_ST;
      GAMEOVER_ST: if (restart) state_d = RESPAWN_ST;
      default:     state_d = IDLE_ST;
    endcase
  end

  always_comb begin
    bus.lives          = lives_q;
    bus.star           = star_q;
    bus.player_visible = visible_q;
    bus.GameOver       = (state_q == GAMEOVER_ST);
    bus.respawn        = (state_q == RESPAWN_ST);
    bus.invulnerable   = (state_q == INVULN_ST);
  end

  always_comb begin
    lives_d   = lives_q;
    blink_d   = blink_q;
    visible_d = visible_q;
    star_d    = star_q;
    // Restart needs start_game seen low inside GAMEOVER_ST first, so a held key cannot restart.
    armed_d   = (state_q == GAMEOVER_ST) ? (armed_q || !bus.start_game) : 1'b0;

    if (restart) begin
      lives_d = LIVES_INIT;
    end else if ((state_q == HIT_ST) && (lives_q != '0)) begin
      lives_d = lives_q - LIVES_W'(1);
    end

    case (state_q)
      RESPAWN_ST: begin
        blink_d   = '0;
        visible_d = 1'b1;
      end
      INVULN_ST: begin
        if (inv_zero) begin
          visible_d = 1'b1;
        end else if (bus.startOfFrame) begin
          if (blink_q == BLINK_LAST) begin
            blink_d   = '0;
            visible_d = !visible_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end
      GAMEOVER_ST: visible_d = 1'b1;
      default: ;
    endcase

    if (state_q == GAMEOVER_ST) begin
      star_d = 1'b0;
    end else if (pickup_ok) begin
      star_d = 1'b1;
    end
`ifdef PLAYER_STAR_TIMEOUT_EN
    else if (star_q && star_zero) begin
      star_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives_q   <= LIVES_INIT;
      blink_q   <= '0;
      visible_q <= 1'b1;
      star_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      lives_q   <= lives_d;
      blink_q   <= blink_d;
      visible_q <= visible_d;
      star_q    <= star_d;
      armed_q   <= armed_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetN)
                                   (state_q == HIT_ST) |-> (lives_q != '0));
  a_invuln_range: assert property (@(posedge clk) disable iff (!resetN)
                                   inv_count <= INVULN_LOAD);

endmodule

// File: tb/tb_player_life_ctrl.sv
// tb/tb_player_life_ctrl.sv - table-driven scoreboard bench for player_life_ctrl
module tb_player_life_ctrl;

`ifdef PLAYER_STAR_TIMEOUT_EN
  localparam bit STAR_TO = 1'b1;
`else
  localparam bit STAR_TO = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         sg;
    bit         en;
    bit         sp;
    int         nfr;
    logic [2:0] lives;
    bit         go;
    bit         star;
    bit         resp;
    bit         inv;
    bit         vis;
  } vec_t;

  typedef logic [7:0] out_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  player_life_ctrl_if bus();

  player_life_ctrl #(
    .INITIAL_LIVES (3),
    .INVULN_FRAMES (60),
    .BLINK_PERIOD  (4),
    .STAR_FRAMES   (300)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  out_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  vec_t  tbl[$];

  function automatic vec_t mk(string n, bit sg, bit en, bit sp, int nfr,
                              int lives, bit go, bit star, bit resp, bit inv, bit vis);
    vec_t v;
    v.name = n; v.sg = sg; v.en = en; v.sp = sp; v.nfr = nfr;
    v.lives = 3'(lives); v.go = go; v.star = star; v.resp = resp; v.inv = inv; v.vis = vis;
    return v;
  endfunction

  function automatic out_t pack_exp(vec_t v);
    return {v.lives, v.go, v.star, v.resp, v.inv, v.vis};
  endfunction

  function automatic out_t dut_out();
    return {bus.lives, bus.GameOver, bus.star, bus.respawn, bus.invulnerable, bus.player_visible};
  endfunction

  task automatic push_exp(vec_t v);
    exp_q.push_back(pack_exp(v));
    name_q.push_back(v.name);
  endtask

  task automatic check_next();
    out_t  got, exp;
    string nm;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: output sampled with no expectation queued");
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    got = dut_out();
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got lives=%0d go=%b star=%b resp=%b inv=%b vis=%b, expected lives=%0d go=%b star=%b resp=%b inv=%b vis=%b",
               nm, got[7:5], got[4], got[3], got[2], got[1], got[0],
               exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic clear_inputs();
    bus.start_game       = 1'b0;
    bus.col_player_enemy = 1'b0;
    bus.col_player_star  = 1'b0;
    bus.startOfFrame     = 1'b0;
  endtask

  // nfr==0: one clock with the inputs; otherwise nfr frames of 3 clocks, startOfFrame on the first.
  task automatic apply(vec_t v);
    push_exp(v);
    bus.start_game       = v.sg;
    bus.col_player_enemy = v.en;
    bus.col_player_star  = v.sp;
    if (v.nfr == 0) begin
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < v.nfr; i++) begin
        bus.startOfFrame = 1'b1;
        @(posedge clk); #1;
        bus.startOfFrame = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    clear_inputs();
    check_next();
  endtask

  task automatic async_reset_check(string nm);
    push_exp(mk(nm, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1));
    resetN = 1'b0;
    #1;
    check_next();
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  initial begin
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    push_exp(mk("reset_state", 0, 0, 0, 0, 3, 0, 0, 0, 0, 1));
    check_next();
    resetN = 1'b1;

    //             name              sg en sp nfr  lv go st rs iv vs
    tbl.push_back(mk("idle_hold",     0, 0, 0, 0,   3, 0, 0, 0, 0, 1));
    tbl.push_back(mk("start_respawn", 1, 0, 0, 0,   3, 0, 0, 1, 0, 1));
    tbl.push_back(mk("enter_invuln",  0, 0, 0, 0,   3, 0, 0, 0, 1, 1));
    tbl.push_back(mk("blink_f3",      0, 0, 0, 3,   3, 0, 0, 0, 1, 1));
    tbl.push_back(mk("blink_f4",      0, 0, 0, 1,   3, 0, 0, 0, 1, 0));
    tbl.push_back(mk("blink_f7",      0, 0, 0, 3,   3, 0, 0, 0, 1, 0));
    tbl.push_back(mk("blink_f8",      0, 0, 0, 1,   3, 0, 0, 0, 1, 1));
    tbl.push_back(mk("invuln_enemy",  0, 1, 0, 1,   3, 0, 0, 0, 1, 1));
    tbl.push_back(mk("invuln_f59",    0, 0, 0, 50,  3, 0, 0, 0, 1, 1));
    tbl.push_back(mk("invuln_exit",   0, 0, 0, 1,   3, 0, 0, 0, 0, 1));
    tbl.push_back(mk("hit1_state",    0, 1, 0, 0,   3, 0, 0, 0, 0, 1));
    tbl.push_back(mk("hit1_respawn",  0, 0, 0, 0,   2, 0, 0, 1, 0, 1));
    tbl.push_back(mk("hit1_invuln",   0, 0, 0, 0,   2, 0, 0, 0, 1, 1));
    tbl.push_back(mk("immune_f59",    0, 1, 0, 59,  2, 0, 0, 0, 1, 1));
    tbl.push_back(mk("immune_exit",   0, 0, 0, 1,   2, 0, 0, 0, 0, 1));
    tbl.push_back(mk("hit_vs_pickup", 0, 1, 1, 0,   2, 0, 0, 0, 0, 1));
    tbl.push_back(mk("hit2_respawn",  0, 0, 0, 0,   1, 0, 0, 1, 0, 1));
    tbl.push_back(mk("hit2_invuln",   0, 0, 0, 0,   1, 0, 0, 0, 1, 1));
    tbl.push_back(mk("hit2_exit",     0, 0, 0, 60,  1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("hit3_state",    0, 1, 0, 0,   1, 0, 0, 0, 0, 1));
    tbl.push_back(mk("gameover",      0, 0, 0, 0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("held_start",    1, 0, 0, 2,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("release_start", 0, 0, 0, 0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk("restart",       1, 0, 0, 0,   3, 0, 0, 1, 0, 1));
    tbl.push_back(mk("restart_inv",   0, 0, 0, 0,   3, 0, 0, 0, 1, 1));
    tbl.push_back(mk("pickup_invuln", 0, 0, 1, 0,   3, 0, 1, 0, 1, 1));
    tbl.push_back(mk("star_f59",      0, 1, 0, 59,  3, 0, 1, 0, 1, 1));
    tbl.push_back(mk("star_exit",     0, 0, 0, 1,   3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_blocks",   0, 1, 0, 0,   3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_no_hit",   0, 0, 0, 0,   3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_reload0",  0, 0, 1, 0,   3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_f200",     0, 0, 0, 200, 3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_reload1",  0, 0, 1, 0,   3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_f499",     0, 0, 0, 299, 3, 0, 1, 0, 0, 1));
    tbl.push_back(mk("star_f500",     0, 0, 0, 1,   3, 0, !STAR_TO, 0, 0, 1));

    foreach (tbl[i]) apply(tbl[i]);

    // Async reset landing mid-INVULN, after a life is lost and star picked up.
    async_reset_check("reset_pre_seq");
    apply(mk("rs_start",      1, 0, 0, 0,  3, 0, 0, 1, 0, 1));
    apply(mk("rs_invuln",     0, 0, 0, 0,  3, 0, 0, 0, 1, 1));
    apply(mk("rs_play",       0, 0, 0, 60, 3, 0, 0, 0, 0, 1));
    apply(mk("rs_hit",        0, 1, 0, 0,  3, 0, 0, 0, 0, 1));
    apply(mk("rs_respawn",    0, 0, 0, 0,  2, 0, 0, 1, 0, 1));
    apply(mk("rs_invuln2",    0, 0, 0, 0,  2, 0, 0, 0, 1, 1));
    apply(mk("rs_blink",      0, 0, 0, 4,  2, 0, 0, 0, 1, 0));
    apply(mk("rs_pickup",     0, 0, 1, 0,  2, 0, 1, 0, 1, 0));
    #3;
    async_reset_check("async_reset_mid_invuln");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
